// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline types and constants for the hazard logic.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Hazard controller states: normal flow, or frozen behind a mul/div in EX
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hc_state_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Flags an ID instruction that reads the destination of the
//               load currently in EX (register zero never creates a hazard).
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    output logic                  load_use
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (ex_rt == id_rs);
    assign w_rt_match = id_uses_rt & (ex_rt == id_rt);
    assign load_use   = ex_mem_read & (ex_rt != REG_ZERO) & (w_rs_match | w_rt_match);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : Pipeline stall/flush control for load-use hazards, taken
//               branches and multi-cycle mul/div occupancy of EX, with a
//               saturating stall-cycle performance counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int MD_LATENCY  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_md_start,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_rt,
    input  logic                   branch_taken,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_write,
    output logic                   id_ex_flush,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // A single-cycle mul/div never needs the wait state; otherwise the
    // counter is preloaded so the freeze spans MD_LATENCY-1 cycles.
    localparam logic       c_md_multi = (MD_LATENCY > 1);
    localparam logic [3:0] c_md_load  = 4'((MD_LATENCY > 1) ? (MD_LATENCY - 2) : 0);

    hc_state_t              r_state;
    hc_state_t              w_next_state;
    logic [3:0]             r_md_cnt;
    logic [3:0]             w_md_cnt_next;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_load_use;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .load_use    (w_load_use)
    );

    // State and mul/div countdown registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= RUN;
            r_md_cnt <= 4'd0;
        end else begin
            r_state  <= w_next_state;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    // Next-state and same-cycle pipeline control; branch beats load-use beats mul/div
    always_comb begin
        w_next_state  = r_state;
        w_md_cnt_next = r_md_cnt;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        md_busy       = 1'b0;
        case (r_state)
            RUN: begin
                if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (id_md_start && c_md_multi) begin
                    w_next_state  = MD_WAIT;
                    w_md_cnt_next = c_md_load;
                end
            end
            MD_WAIT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_write = 1'b0;
                md_busy     = 1'b1;
                if (r_md_cnt == 4'd0) begin
                    w_next_state = RUN;
                end else begin
                    w_md_cnt_next = r_md_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (!pc_write && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cnt;

endmodule : hazard_controller
`default_nettype wire

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have parameter MD_LATENCY, default 4: the number of cycles a mul/div instruction occupies EX (range 1..15).
REQ-002 The block SHALL have parameter STALL_CNT_W, default 16: the width of the stall performance counter.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on the posedge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port id_rs, input, 5 bits: rs field of the instruction in ID.
REQ-006 The block SHALL have port id_rt, input, 5 bits: rt field of the instruction in ID.
REQ-007 The block SHALL have port id_uses_rt, input, 1 bit: the ID instruction reads rt as a source.
REQ-008 The block SHALL have port id_md_start, input, 1 bit: the ID instruction is a mul/div.
REQ-009 The block SHALL have port ex_mem_read, input, 1 bit: the EX instruction is a load.
REQ-010 The block SHALL have port ex_rt, input, 5 bits: destination register of the EX load.
REQ-011 The block SHALL have port branch_taken, input, 1 bit: a branch resolved taken in EX this cycle.
REQ-012 The block SHALL have port pc_write, output, 1 bit: PC update enable.
REQ-013 The block SHALL have port if_id_write, output, 1 bit: IF/ID register update enable.
REQ-014 The block SHALL have port if_id_flush, output, 1 bit: load a NOP into IF/ID.
REQ-015 The block SHALL have port id_ex_write, output, 1 bit: ID/EX register update enable.
REQ-016 The block SHALL have port id_ex_flush, output, 1 bit: load a bubble (all controls 0) into ID/EX.
REQ-017 The block SHALL have port md_busy, output, 1 bit: a mul/div is occupying EX.
REQ-018 The block SHALL have port stall_cycles, output, STALL_CNT_W bits: count of cycles with pc_write=0.

Function
REQ-019 The block SHALL implement a state machine with states RUN and MD_WAIT plus a 4-bit down-counter md_cnt; outputs SHALL be combinational from state and inputs (same-cycle effect).
REQ-020 The block SHALL define load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
REQ-021 In RUN with branch_taken=1, the block SHALL drive pc_write=1, if_id_flush=1, id_ex_flush=1, id_ex_write=1 and stay in RUN; branch SHALL take priority over load_use and id_md_start.
REQ-022 In RUN with load_use=1 and no branch, the block SHALL drive pc_write=0, if_id_write=0, id_ex_flush=1 for that cycle only; id_md_start SHALL be ignored that cycle.
REQ-023 In RUN with id_md_start=1, no branch and no load_use, if MD_LATENCY>1 the block SHALL advance normally, go to MD_WAIT and load md_cnt=MD_LATENCY-2; if MD_LATENCY=1 it SHALL stay in RUN.
REQ-024 In RUN otherwise, the block SHALL drive pc_write=if_id_write=id_ex_write=1 with both flushes 0.
REQ-025 In MD_WAIT, the block SHALL drive pc_write=0, if_id_write=0, id_ex_write=0, both flushes 0 and md_busy=1; it SHALL ignore branch_taken and load_use.
REQ-026 In MD_WAIT, the block SHALL return to RUN when md_cnt==0, else decrement md_cnt; the freeze SHALL last exactly MD_LATENCY-1 cycles.
REQ-027 md_busy SHALL be 0 in RUN.
REQ-028 stall_cycles SHALL increment by 1 on each cycle with pc_write=0 and saturate at all-ones (no wrap).

Reset
REQ-029 While reset_n=0 at posedge, the block SHALL set state=RUN, md_cnt=0 and stall_cycles=0.
REQ-030 Reset mid-MD_WAIT SHALL abort the wait; the first cycle after reset SHALL be RUN with md_busy=0.
REQ-031 Outputs during reset cycles SHALL follow RUN rules from current state after the first reset edge.

Structure
REQ-032 The shared package pipeline_pkg SHALL hold the state enum (RUN, MD_WAIT), REG_ADDR_W=5 and REG_ZERO=5'd0.
REQ-033 The load_use comparison SHALL be a combinational sub-module load_use_detect; the FSM, counter and stall counter SHALL stay in hazard_controller.

Verification
REQ-034 Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_flush=1, then normal flow; stall_cycles +1.
REQ-035 Register zero: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall.
REQ-036 rt unused: ex_rt=9, id_rt=9, id_uses_rt=0, id_rs=3 -> no stall.
REQ-037 Mul/div with MD_LATENCY=4: id_md_start pulse -> md_busy=1 and pc_write=0 for exactly 3 cycles; branch_taken=1 during the wait has no effect; stall_cycles +3.
REQ-038 Simultaneous events: branch_taken=1 together with load_use=1 and id_md_start=1 -> flushes asserted, pc_write=1, state stays RUN.
REQ-039 Reset and saturation: reset_n=0 on the 2nd MD_WAIT cycle -> RUN with counters 0 next cycle; with STALL_CNT_W=4, 20 stall cycles -> stall_cycles holds 15.
